// File: rtl/spi_mem_slave_ctrl.sv
// spi_mem_slave_ctrl
// SPI slave transaction controller between the SCLK/CS/MOSI conditioners and
// a data memory. Decodes an ADDR_W-bit address plus a R/W bit (MSB first),
// then either commits DATA_W-bit words to memory or shifts memory words out
// on MISO. With BURST_EN=1 the address auto-increments (and wraps) while CS
// stays low; a CS release aborts cleanly and discards partial words.
//
// Ports:
//   clk        internal clock, all logic on posedge
//   reset      asynchronous active-high reset
//   sclk_rise  one-clk pulse per conditioned SCLK rising edge
//   sclk_fall  one-clk pulse per conditioned SCLK falling edge
//   cs_n       conditioned chip select, active-low
//   mosi       conditioned MOSI, sampled on sclk_rise
//   dm_dout    memory read data (combinational from dm_addr)
//   dm_addr    memory address
//   dm_din     memory write data
//   dm_we      memory write enable, one clk per word
//   miso       serial read data
//   miso_bufe  MISO tri-state enable, high only while serving a read
//   busy       high whenever the controller is not idle
module spi_mem_slave_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int BURST_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic [DATA_W-1:0] dm_dout,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  output logic              miso,
  output logic              miso_bufe,
  output logic              busy
);

  localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CW = $clog2(SW + 1);

  localparam logic [CW-1:0] CNT_ADDR  = CW'(ADDR_W);
  localparam logic [CW-1:0] CNT_DLAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    WCOMMIT,
    RLOAD,
    RDATA,
    HOLD
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sr;
  logic            cmd_done;
  logic            word_done;

  // Final command rise carries the R/W bit; final data rise closes a word.
  assign cmd_done  = sclk_rise && (cnt == CNT_ADDR);
  assign word_done = sclk_rise && (cnt == CNT_DLAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a CS release outranks every other transition
  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (!cs_n) state_nx = CMD;
    end else if (cs_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        CMD:     if (cmd_done) state_nx = mosi ? RLOAD : WDATA;
        WDATA:   if (word_done) state_nx = WCOMMIT;
        WCOMMIT: state_nx = (BURST_EN != 0) ? WDATA : HOLD;
        RLOAD:   state_nx = RDATA;
        RDATA:   if (word_done) state_nx = (BURST_EN != 0) ? RLOAD : HOLD;
        default: state_nx = state;
      endcase
    end
  end

  // Datapath: bit counter, shift register, address and write-data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      sr      <= '0;
      dm_addr <= '0;
      dm_din  <= '0;
    end else if (state == IDLE || cs_n) begin
      cnt <= '0;
      sr  <= '0;
    end else begin
      case (state)
        CMD: begin
          if (sclk_rise) begin
            if (cnt == CNT_ADDR) begin
              // sr still holds the ADDR_W address bits; mosi is the R/W bit
              dm_addr <= sr[ADDR_W-1:0];
              cnt     <= '0;
              sr      <= '0;
            end else begin
              sr  <= {sr[SW-2:0], mosi};
              cnt <= cnt + CW'(1);
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            if (cnt == CNT_DLAST) begin
              dm_din <= {sr[DATA_W-2:0], mosi};
              cnt    <= '0;
              sr     <= '0;
            end else begin
              sr  <= {sr[SW-2:0], mosi};
              cnt <= cnt + CW'(1);
            end
          end
        end
        WCOMMIT: begin
          dm_addr <= dm_addr + ADDR_W'(1);
          cnt     <= '0;
        end
        RLOAD: begin
          sr  <= SW'(dm_dout);
          cnt <= '0;
        end
        RDATA: begin
          if (sclk_rise) begin
            if (cnt == CNT_DLAST) begin
              dm_addr <= dm_addr + ADDR_W'(1);
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          // The fall at count 0 is the trailing edge of the command bit (or
          // of the previous word's last bit) and must not shift.
          if (sclk_fall && cnt != '0) begin
            sr <= {sr[SW-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    dm_we     = 1'b0;
    miso_bufe = 1'b0;
    miso      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      WCOMMIT: dm_we = 1'b1;
      RLOAD:   miso_bufe = 1'b1;
      RDATA: begin
        miso_bufe = 1'b1;
        miso      = sr[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_mem_slave_ctrl.sv
// Directed bench for spi_mem_slave_ctrl: one burst-enabled instance (a) and
// one single-word instance (b) share the SPI stimulus, each with its own
// behavioural memory.
module tb_spi_mem_slave_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk_rise = 1'b0;
  logic       sclk_fall = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;

  logic [7:0] dm_dout_a, dm_dout_b;
  logic [6:0] dm_addr_a, dm_addr_b;
  logic [7:0] dm_din_a, dm_din_b;
  logic       dm_we_a, dm_we_b;
  logic       miso_a, miso_b;
  logic       miso_bufe_a, miso_bufe_b;
  logic       busy_a, busy_b;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  int nwr_a = 0;
  int nwr_b = 0;
  int bufe_cnt_a = 0;
  int bufe_cnt_b = 0;
  logic [6:0] wr_addr_a [64];
  logic [7:0] wr_data_a [64];
  int         wr_cyc_a  [64];

  always #5 clk = ~clk;

  assign dm_dout_a = mem_a[dm_addr_a];
  assign dm_dout_b = mem_b[dm_addr_b];

  spi_mem_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1)) dut_a (
    .clk(clk), .reset(reset), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs_n(cs_n), .mosi(mosi), .dm_dout(dm_dout_a), .dm_addr(dm_addr_a),
    .dm_din(dm_din_a), .dm_we(dm_we_a), .miso(miso_a),
    .miso_bufe(miso_bufe_a), .busy(busy_a)
  );

  spi_mem_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(0)) dut_b (
    .clk(clk), .reset(reset), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs_n(cs_n), .mosi(mosi), .dm_dout(dm_dout_b), .dm_addr(dm_addr_b),
    .dm_din(dm_din_b), .dm_we(dm_we_b), .miso(miso_b),
    .miso_bufe(miso_bufe_b), .busy(busy_b)
  );

  always @(negedge clk) cyc = cyc + 1;

  // Behavioural memories plus a log of instance a's write strobes
  always @(posedge clk) begin
    if (dm_we_a) begin
      mem_a[dm_addr_a] = dm_din_a;
      wr_addr_a[nwr_a % 64] = dm_addr_a;
      wr_data_a[nwr_a % 64] = dm_din_a;
      wr_cyc_a[nwr_a % 64]  = cyc;
      nwr_a = nwr_a + 1;
    end
    if (dm_we_b) begin
      mem_b[dm_addr_b] = dm_din_b;
      nwr_b = nwr_b + 1;
    end
    if (miso_bufe_a) bufe_cnt_a = bufe_cnt_a + 1;
    if (miso_bufe_b) bufe_cnt_b = bufe_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One SCLK period: MOSI set up, miso sampled just before the rise pulse,
  // then a fall pulse; each half-period is at least 3 clk.
  task automatic xfer(input logic b, output logic sa, output logic sb);
    @(posedge clk); #1 mosi = b;
    repeat (2) @(posedge clk);
    #1;
    sa = miso_a;
    sb = miso_b;
    sclk_rise = 1'b1;
    @(posedge clk);
    last_rise = cyc;
    #1 sclk_rise = 1'b0;
    repeat (2) @(posedge clk);
    #1 sclk_fall = 1'b1;
    @(posedge clk);
    #1 sclk_fall = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    logic sa, sb;
    for (int i = n - 1; i >= 0; i--) xfer(v[i], sa, sb);
  endtask

  task automatic read_word(output logic [7:0] ra, output logic [7:0] rb);
    logic sa, sb;
    for (int i = 7; i >= 0; i--) begin
      xfer(1'b0, sa, sb);
      ra[i] = sa;
      rb[i] = sb;
    end
  endtask

  task automatic cs_low();
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic cs_high();
    @(posedge clk); #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] part;
    logic sa, sb;
    int base_a, base_b, bcnt, wr_rise;

    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[7'h2A] = 8'h3C;
    mem_b[7'h2A] = 8'h3C;
    mem_a[7'h05] = 8'hC3;
    mem_b[7'h05] = 8'hC3;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(dm_addr_a), 32'h0);
    chk("rst_din", 32'(dm_din_a), 32'h0);
    chk("rst_we", 32'(dm_we_a), 32'h0);
    chk("rst_miso", 32'(miso_a), 32'h0);
    chk("rst_bufe", 32'(miso_bufe_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single write: 0xA5 to 0x15
    base_a = nwr_a;
    bcnt = bufe_cnt_a;
    cs_low();
    #1 chk("wr_busy", 32'(busy_a), 32'h1);
    send(16'h15, 7);
    send(16'h0, 1);
    send(16'hA5, 8);
    wr_rise = last_rise;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_count", 32'(nwr_a - base_a), 32'd1);
    chk("wr_addr", 32'(wr_addr_a[base_a % 64]), 32'h15);
    chk("wr_data", 32'(wr_data_a[base_a % 64]), 32'hA5);
    chk("wr_latency", 32'(wr_cyc_a[base_a % 64] - wr_rise), 32'd1);
    chk("wr_no_bufe", 32'(bufe_cnt_a - bcnt), 32'd0);
    chk("wr_addr_inc", 32'(dm_addr_a), 32'h16);
    cs_high();
    chk("wr_idle", 32'(busy_a), 32'h0);

    // Single read of 0x2A (holds 0x3C)
    cs_low();
    send(16'h2A, 7);
    send(16'h1, 1);
    #1 chk("rd_bufe_on", 32'(miso_bufe_a), 32'h1);
    read_word(ra, rb);
    chk("rd_data", 32'(ra), 32'h3C);
    @(posedge clk); #1 cs_n = 1'b1;
    @(posedge clk); #1;
    chk("rd_bufe_off", 32'(miso_bufe_a), 32'h0);
    chk("rd_busy_off", 32'(busy_a), 32'h0);
    repeat (3) @(posedge clk);

    // Burst write with address wrap: 0x11 to 0x7F, 0x22 to 0x00
    base_a = nwr_a;
    base_b = nwr_b;
    cs_low();
    send(16'h7F, 7);
    send(16'h0, 1);
    send(16'h11, 8);
    send(16'h22, 8);
    repeat (3) @(posedge clk);
    cs_high();
    chk("bw_count", 32'(nwr_a - base_a), 32'd2);
    chk("bw_addr0", 32'(wr_addr_a[base_a % 64]), 32'h7F);
    chk("bw_data0", 32'(wr_data_a[base_a % 64]), 32'h11);
    chk("bw_addr1", 32'(wr_addr_a[(base_a + 1) % 64]), 32'h00);
    chk("bw_data1", 32'(wr_data_a[(base_a + 1) % 64]), 32'h22);
    chk("bw_single_cnt", 32'(nwr_b - base_b), 32'd1);

    // Abort after 4 data bits, then a complete write to the same address
    base_a = nwr_a;
    cs_low();
    send(16'h10, 7);
    send(16'h0, 1);
    send(16'hA, 4);
    @(posedge clk); #1 cs_n = 1'b1;
    @(posedge clk); #1;
    chk("ab_idle", 32'(busy_a), 32'h0);
    chk("ab_we", 32'(dm_we_a), 32'h0);
    repeat (4) @(posedge clk);
    chk("ab_no_write", 32'(nwr_a - base_a), 32'd0);
    cs_low();
    send(16'h10, 7);
    send(16'h0, 1);
    send(16'h55, 8);
    repeat (3) @(posedge clk);
    cs_high();
    chk("ab_rewr_cnt", 32'(nwr_a - base_a), 32'd1);
    chk("ab_rewr_addr", 32'(wr_addr_a[base_a % 64]), 32'h10);
    chk("ab_rewr_mem", 32'(mem_a[7'h10]), 32'h55);

    // Single-word instance: read 0x05 then 8 extra SCLK cycles
    cs_low();
    send(16'h05, 7);
    send(16'h1, 1);
    #1 chk("nb_bufe_on", 32'(miso_bufe_b), 32'h1);
    read_word(ra, rb);
    chk("nb_data", 32'(rb), 32'hC3);
    bcnt = bufe_cnt_b;
    read_word(ra, rb);
    chk("nb_extra_bits", 32'(rb), 32'h00);
    chk("nb_extra_bufe", 32'(bufe_cnt_b - bcnt), 32'd0);
    chk("nb_addr", 32'(dm_addr_b), 32'h06);
    chk("nb_hold_busy", 32'(busy_b), 32'h1);
    cs_high();

    // Reset in the middle of a read, then a fresh read
    cs_low();
    send(16'h2A, 7);
    send(16'h1, 1);
    for (int i = 2; i >= 0; i--) begin
      xfer(1'b0, sa, sb);
      part[i] = sa;
    end
    chk("rr_part", 32'(part), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rr_addr", 32'(dm_addr_a), 32'h0);
    chk("rr_din", 32'(dm_din_a), 32'h0);
    chk("rr_bufe", 32'(miso_bufe_a), 32'h0);
    chk("rr_miso", 32'(miso_a), 32'h0);
    chk("rr_busy", 32'(busy_a), 32'h0);
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    cs_low();
    send(16'h2A, 7);
    send(16'h1, 1);
    read_word(ra, rb);
    chk("rr_reread", 32'(ra), 32'h3C);
    cs_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
